// File: rtl/target_box_finder.sv
// Per-frame bounding box of pixels inside an RGB window, published once per frame at vsync.
// Latency: box_upd 3 clk after vsync rise at the pin; no backpressure, results held stable for a frame.
module target_box_finder #(
    parameter int H_ACT    = 1280,
    parameter int V_ACT    = 720,
    parameter int MIN_PIX  = 64,
    parameter int HOLD_FRM = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pix_valid,
    input  logic        vsync,
    input  logic        de,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [23:0] rgb,
    input  logic [23:0] thr_lo,
    input  logic [23:0] thr_hi,
    output logic [10:0] start_xs,
    output logic [9:0]  start_ys,
    output logic [10:0] end_xs,
    output logic [9:0]  end_ys,
    output logic [20:0] pix_cnt,
    output logic        found,
    output logic        box_upd
);

    localparam logic [10:0] X_LIM    = 11'(H_ACT);
    localparam logic [9:0]  Y_LIM    = 10'(V_ACT);
    localparam logic [10:0] X_MAX    = 11'(H_ACT - 1);
    localparam logic [9:0]  Y_MAX    = 10'(V_ACT - 1);
    localparam logic [20:0] CNT_MIN  = 21'(MIN_PIX);
    localparam int          MW       = $clog2(HOLD_FRM + 1);
    localparam logic [MW-1:0] MISS_LIM = MW'(HOLD_FRM);

    typedef enum logic [1:0] {WAIT_VS, ACCUM, COMMIT} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_vs_s1, r_vs_s2;
    logic        w_vs_rise;
    logic [2:0]  w_ch_ok;
    logic        w_match;
    logic        r_m_vld;
    logic [10:0] r_m_x;
    logic [9:0]  r_m_y;

    logic [10:0] r_min_x, r_max_x, w_base_min_x, w_base_max_x, w_nxt_min_x, w_nxt_max_x;
    logic [9:0]  r_min_y, r_max_y, w_base_min_y, w_base_max_y, w_nxt_min_y, w_nxt_max_y;
    logic [20:0] r_cnt, w_base_cnt, w_nxt_cnt;

    logic [MW-1:0] r_miss, w_miss_inc;
    logic          w_hit;

    logic [10:0] r_start_xs, r_end_xs;
    logic [9:0]  r_start_ys, r_end_ys;
    logic [20:0] r_pix_cnt;
    logic        r_found, r_box_upd;

    always_comb begin
        w_ch_ok = '0;
        for (int i = 0; i < 3; i++) begin
            w_ch_ok[i] = (rgb[8*i +: 8] >= thr_lo[8*i +: 8]) && (rgb[8*i +: 8] <= thr_hi[8*i +: 8]);
        end
    end

    assign w_match   = pix_valid & de & (x < X_LIM) & (y < Y_LIM) & (&w_ch_ok);
    assign w_vs_rise = r_vs_s1 & ~r_vs_s2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vs_s1 <= 1'b0;
            r_vs_s2 <= 1'b0;
            r_m_vld <= 1'b0;
            r_m_x   <= '0;
            r_m_y   <= '0;
            r_state <= WAIT_VS;
        end else begin
            r_vs_s1 <= vsync;
            r_vs_s2 <= r_vs_s1;
            r_m_vld <= w_match;
            r_m_x   <= x;
            r_m_y   <= y;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_VS: if (w_vs_rise) w_state_nxt = ACCUM;
            ACCUM:   if (w_vs_rise) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = ACCUM;
            default: w_state_nxt = WAIT_VS;
        endcase
    end

    // Outside ACCUM the accumulators start from the cleared values, so a match landing
    // in COMMIT seeds the next frame instead of being dropped.
    always_comb begin
        w_base_min_x = X_MAX;
        w_base_min_y = Y_MAX;
        w_base_max_x = '0;
        w_base_max_y = '0;
        w_base_cnt   = '0;
        if (r_state == ACCUM) begin
            w_base_min_x = r_min_x;
            w_base_min_y = r_min_y;
            w_base_max_x = r_max_x;
            w_base_max_y = r_max_y;
            w_base_cnt   = r_cnt;
        end
        w_nxt_min_x = w_base_min_x;
        w_nxt_min_y = w_base_min_y;
        w_nxt_max_x = w_base_max_x;
        w_nxt_max_y = w_base_max_y;
        w_nxt_cnt   = w_base_cnt;
        if (r_m_vld && (r_state != WAIT_VS)) begin
            if (r_m_x < w_base_min_x) w_nxt_min_x = r_m_x;
            if (r_m_y < w_base_min_y) w_nxt_min_y = r_m_y;
            if (r_m_x > w_base_max_x) w_nxt_max_x = r_m_x;
            if (r_m_y > w_base_max_y) w_nxt_max_y = r_m_y;
            if (w_base_cnt != '1)     w_nxt_cnt   = w_base_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_min_x <= X_MAX;
            r_min_y <= Y_MAX;
            r_max_x <= '0;
            r_max_y <= '0;
            r_cnt   <= '0;
        end else begin
            r_min_x <= w_nxt_min_x;
            r_min_y <= w_nxt_min_y;
            r_max_x <= w_nxt_max_x;
            r_max_y <= w_nxt_max_y;
            r_cnt   <= w_nxt_cnt;
        end
    end

    assign w_hit      = (r_cnt >= CNT_MIN);
    assign w_miss_inc = (r_miss >= MISS_LIM) ? r_miss : r_miss + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start_xs <= '0;
            r_start_ys <= '0;
            r_end_xs   <= '0;
            r_end_ys   <= '0;
            r_pix_cnt  <= '0;
            r_found    <= 1'b0;
            r_box_upd  <= 1'b0;
            r_miss     <= '0;
        end else if (r_state == COMMIT) begin
            r_box_upd <= 1'b1;
            r_pix_cnt <= r_cnt;
            if (w_hit) begin
                r_start_xs <= r_min_x;
                r_start_ys <= r_min_y;
                r_end_xs   <= r_max_x;
                r_end_ys   <= r_max_y;
                r_found    <= 1'b1;
                r_miss     <= '0;
            end else begin
                r_miss <= w_miss_inc;
                if (w_miss_inc >= MISS_LIM) begin
                    r_start_xs <= '0;
                    r_start_ys <= '0;
                    r_end_xs   <= '0;
                    r_end_ys   <= '0;
                    r_found    <= 1'b0;
                end
            end
        end else begin
            r_box_upd <= 1'b0;
        end
    end

    assign start_xs = r_start_xs;
    assign start_ys = r_start_ys;
    assign end_xs   = r_end_xs;
    assign end_ys   = r_end_ys;
    assign pix_cnt  = r_pix_cnt;
    assign found    = r_found;
    assign box_upd  = r_box_upd;

endmodule
